// File: rtl/dds_wave_shaper_if.sv
// dds_wave_shaper_if
//   Bundles the phase input, the quarter-wave ROM port and the sample output
//   of the DDS wave shaper.
//   master : phase source / ROM / sample sink side
//   slave  : wave shaper side
//   Signals: phase_in, phase_vld, p_off, wave_sel, amp  (to shaper)
//            rom_addr, rom_en -> ROM, rom_data <- ROM  (1-cycle latency)
//            wave_out, wave_vld                        (from shaper)
interface dds_wave_shaper_if #(
    parameter int PW = 11,
    parameter int DW = 10
);
    logic [PW-1:0] phase_in;
    logic          phase_vld;
    logic [PW-1:0] p_off;
    logic [1:0]    wave_sel;
    logic [8:0]    amp;
    logic [PW-3:0] rom_addr;
    logic          rom_en;
    logic [DW-2:0] rom_data;
    logic [DW-1:0] wave_out;
    logic          wave_vld;

    modport master (
        output phase_in, phase_vld, p_off, wave_sel, amp, rom_data,
        input  rom_addr, rom_en, wave_out, wave_vld
    );

    modport slave (
        input  phase_in, phase_vld, p_off, wave_sel, amp, rom_data,
        output rom_addr, rom_en, wave_out, wave_vld
    );
endinterface

// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper
//   Turns the DDS accumulator phase code into an offset-binary DAC sample.
//   Four stages: S0 phase add + ROM address, S1 ROM read, S2 waveform select,
//   S3 amplitude scaling. One sample per clock, 3-edge latency, no stall.
//   Ports: clk, rst_n (async, active low), bus (dds_wave_shaper_if.slave).
module dds_wave_shaper #(
    parameter int PW = 11,
    parameter int DW = 10
) (
    input logic               clk,
    input logic               rst_n,
    dds_wave_shaper_if.slave  bus
);
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    // ---------------- S0: phase offset, ROM address ----------------
    logic [PW-1:0] r_ph0;
    logic [1:0]    r_sel0;
    logic [8:0]    r_amp0;
    logic          r_vld0;
    logic [8:0]    w_amp_c;
    logic [1:0]    w_q;
    logic [PW-3:0] w_idx;

    assign w_amp_c = (bus.amp > 9'd256) ? 9'd256 : bus.amp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph0  <= '0;
            r_sel0 <= '0;
            r_amp0 <= '0;
            r_vld0 <= 1'b0;
        end else begin
            r_ph0  <= bus.phase_in + bus.p_off;   // carry dropped: modulo 2^PW
            r_sel0 <= bus.wave_sel;
            r_amp0 <= w_amp_c;
            r_vld0 <= bus.phase_vld;
        end
    end

    assign w_q          = r_ph0[PW-1:PW-2];
    assign w_idx        = r_ph0[PW-3:0];
    // Quadrants 1 and 3 walk the quarter wave backwards.
    assign bus.rom_addr = w_q[0] ? ~w_idx : w_idx;
    assign bus.rom_en   = r_vld0;

    // ---------------- S1: ROM access, side registers ----------------
    logic [PW-1:0] r_ph1;
    logic [1:0]    r_sel1;
    logic [8:0]    r_amp1;
    logic          r_vld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph1  <= '0;
            r_sel1 <= '0;
            r_amp1 <= '0;
            r_vld1 <= 1'b0;
        end else begin
            r_ph1  <= r_ph0;
            r_sel1 <= r_sel0;
            r_amp1 <= r_amp0;
            r_vld1 <= r_vld0;
        end
    end

    // ---------------- S2: raw waveform ----------------
    logic [DW-1:0] w_mag;
    logic [DW-1:0] w_raw;
    logic [DW-1:0] r_raw;
    logic [8:0]    r_amp2;
    logic          r_vld2;

    assign w_mag = DW'(bus.rom_data);

    always_comb begin
        w_raw = '0;
        unique case (r_sel1)
            // Sine: upper half-cycle above midscale, lower half mirrored below.
            2'b00: w_raw = r_ph1[PW-1] ? (MID - DW'(1)) - w_mag : MID + w_mag;
            // Triangle: fold the second half; inverting the top DW bits equals
            // taking the top DW bits of the inverted code.
            2'b01: w_raw = r_ph1[PW-1] ? ~r_ph1[PW-2 -: DW] : r_ph1[PW-2 -: DW];
            2'b10: w_raw = r_ph1[PW-1 -: DW];
            2'b11: w_raw = {DW{~r_ph1[PW-1]}};
            default: w_raw = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw  <= '0;
            r_amp2 <= '0;
            r_vld2 <= 1'b0;
        end else begin
            r_raw  <= w_raw;
            r_amp2 <= r_amp1;
            r_vld2 <= r_vld1;
        end
    end

    // ---------------- S3: amplitude scaling ----------------
    // |s * amp / 256| <= |s| since amp <= 256, so DW+8 signed bits hold the
    // product exactly and the result cannot overflow.
    logic signed [DW-1:0]   w_s;
    logic signed [9:0]      w_a;
    logic signed [DW+7:0]   w_p;
    logic signed [DW+7:0]   w_sh;
    logic        [DW-1:0]   w_out;
    logic        [DW-1:0]   r_out;
    logic                   r_vld3;

    assign w_s   = signed'(r_raw - MID);
    assign w_a   = signed'({1'b0, r_amp2});
    assign w_p   = (DW+8)'(w_s) * (DW+8)'(w_a);
    assign w_sh  = w_p >>> 8;                 // floor toward -inf
    assign w_out = DW'(w_sh) + MID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= MID;
            r_vld3 <= 1'b0;
        end else begin
            if (r_vld2)
                r_out <= w_out;               // bubbles hold the last sample
            r_vld3 <= r_vld2;
        end
    end

    assign bus.wave_out = r_out;
    assign bus.wave_vld = r_vld3;
endmodule

// File: tb/tb_dds_wave_shaper.sv
module tb_dds_wave_shaper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   exp_held = 512;   // last valid sample expected on wave_out
    logic [8:0] rom_q;

    always #5 clk = ~clk;

    dds_wave_shaper_if #(.PW(11), .DW(10)) bus ();

    dds_wave_shaper #(.PW(11), .DW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM stub: content equals address, one cycle read latency.
    always @(posedge clk) if (bus.rom_en) rom_q <= bus.rom_addr;
    assign bus.rom_data = rom_q;

    // Reference: expected sample from the waveform definitions.
    function automatic int model(int phase, int off, int sel, int amp);
        int ph, q, idx, addr, r, a, p, d;
        ph   = (phase + off) % 2048;
        q    = ph / 512;
        idx  = ph % 512;
        addr = (q % 2 == 1) ? 511 - idx : idx;
        case (sel)
            0:       r = (q < 2) ? 512 + addr : 511 - addr;
            1:       r = (ph < 1024) ? ph : 2047 - ph;
            2:       r = ph / 2;
            default: r = (ph < 1024) ? 1023 : 0;
        endcase
        a = (amp > 256) ? 256 : amp;
        p = (r - 512) * a;
        d = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        return d + 512;
    endfunction

    task automatic send(input int ph, input int off, input int sel, input int amp, input bit v);
        bus.phase_in  = 11'(ph);
        bus.p_off     = 11'(off);
        bus.wave_sel  = 2'(sel);
        bus.amp       = 9'(amp);
        bus.phase_vld = v;
        @(posedge clk); #1;
    endtask

    // One isolated sample: returns ROM address/enable after the capture edge,
    // wave_vld history over the next three edges, and the final wave_out.
    task automatic one(input int ph, input int off, input int sel, input int amp,
                       output int addr, output int en, output int vh, output int out);
        send(ph, off, sel, amp, 1'b1);
        addr = int'(bus.rom_addr);
        en   = int'(bus.rom_en);
        bus.phase_vld = 1'b0;
        vh = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vh = (vh << 1) | int'(bus.wave_vld);
        end
        out = int'(bus.wave_out);
    endtask

    task automatic test_reset;
        bus.phase_in = '0; bus.p_off = '0; bus.wave_sel = '0; bus.amp = 9'd256;
        bus.phase_vld = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (bus.wave_out !== 10'd512 || bus.wave_vld !== 1'b0 || bus.rom_en !== 1'b0 || bus.rom_addr !== 9'd0) begin
            nerr++;
            $display("FAIL reset: out=%0d vld=%0b en=%0b addr=%0d want out=512 vld=0 en=0 addr=0",
                     bus.wave_out, bus.wave_vld, bus.rom_en, bus.rom_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (bus.wave_vld !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle: vld=%0b want 0", bus.wave_vld);
        end
        exp_held = 512;
    endtask

    task automatic test_sine;
        int ph[6]   = '{'h0A0, 'h2A0, 'h4A0, 'h6A0, 'h7F0, 'h7FF};
        int off[6]  = '{0, 0, 0, 0, 'h020, 0};
        int ea[6]   = '{160, 351, 160, 351, 16, 0};
        int eo[6]   = '{672, 863, 351, 160, 528, 511};
        int addr, en, vh, out;
        for (int i = 0; i < 6; i++) begin
            one(ph[i], off[i], 0, 256, addr, en, vh, out);
            nvec++;
            if (addr !== ea[i] || en !== 1) begin
                nerr++;
                $display("FAIL sine_addr[%0d]: addr=%0d en=%0d want addr=%0d en=1", i, addr, en, ea[i]);
            end
            nvec++;
            if (vh !== 3'b001) begin
                nerr++;
                $display("FAIL sine_latency[%0d]: vld history=%03b want 001", i, vh[2:0]);
            end
            nvec++;
            if (out !== eo[i]) begin
                nerr++;
                $display("FAIL sine_out[%0d]: out=%0d want %0d", i, out, eo[i]);
            end
            exp_held = eo[i];
        end
    endtask

    task automatic test_waves;
        int sel[6] = '{1, 1, 1, 2, 3, 3};
        int ph[6]  = '{'h3FF, 'h400, 'h7FF, 'h400, 'h000, 'h400};
        int eo[6]  = '{1023, 1023, 0, 512, 1023, 0};
        int addr, en, vh, out;
        for (int i = 0; i < 6; i++) begin
            one(ph[i], 0, sel[i], 256, addr, en, vh, out);
            nvec++;
            if (vh !== 3'b001 || out !== eo[i]) begin
                nerr++;
                $display("FAIL wave[%0d] sel=%0d: out=%0d vh=%03b want out=%0d vh=001",
                         i, sel[i], out, vh[2:0], eo[i]);
            end
            exp_held = eo[i];
        end
    endtask

    task automatic test_amp;
        int amp[5] = '{255, 128, 0, 300, 256};
        int eo[5]  = '{1021, 767, 512, 1023, 1023};
        int addr, en, vh, out;
        for (int i = 0; i < 5; i++) begin
            one(0, 0, 3, amp[i], addr, en, vh, out);
            nvec++;
            if (out !== eo[i]) begin
                nerr++;
                $display("FAIL amp[%0d]=%0d: out=%0d want %0d", i, amp[i], out, eo[i]);
            end
            exp_held = eo[i];
        end
    endtask

    // Back-to-back random stream with bubbles and per-sample sel/amp changes.
    task automatic test_stream;
        localparam int N = 48;
        int ph[N], off[N], sel[N], amp[N];
        bit v[N];
        int eo;
        for (int i = 0; i < N; i++) begin
            ph[i]  = int'($urandom_range(2047));
            off[i] = int'($urandom_range(2047));
            sel[i] = int'($urandom_range(3));
            amp[i] = int'($urandom_range(320));
            v[i]   = ($urandom_range(3) != 0);
        end
        // Leading 1,0,1 pattern with different waveform and gain per slot.
        ph[0] = 'h0A0; off[0] = 0; sel[0] = 0; amp[0] = 256; v[0] = 1'b1;
        ph[1] = 'h123; off[1] = 0; sel[1] = 2; amp[1] = 50;  v[1] = 1'b0;
        ph[2] = 'h600; off[2] = 0; sel[2] = 1; amp[2] = 100; v[2] = 1'b1;
        for (int i = 0; i < N + 3; i++) begin
            if (i < N) send(ph[i], off[i], sel[i], amp[i], v[i]);
            else       send(0, 0, 0, 0, 1'b0);
            if (i >= 3) begin
                if (v[i-3]) exp_held = model(ph[i-3], off[i-3], sel[i-3], amp[i-3]);
                nvec++;
                if (bus.wave_vld !== v[i-3] || int'(bus.wave_out) !== exp_held) begin
                    nerr++;
                    $display("FAIL stream[%0d]: vld=%0b out=%0d want vld=%0b out=%0d",
                             i - 3, bus.wave_vld, bus.wave_out, v[i-3], exp_held);
                end
            end else begin
                nvec++;
                if (bus.wave_vld !== 1'b0 || int'(bus.wave_out) !== exp_held) begin
                    nerr++;
                    $display("FAIL stream_lead[%0d]: vld=%0b out=%0d want vld=0 out=%0d",
                             i, bus.wave_vld, bus.wave_out, exp_held);
                end
            end
        end
        eo = 0;
        bus.phase_vld = 1'b0;
    endtask

    task automatic test_reset_midstream;
        int addr, en, vh, out, eo;
        for (int i = 0; i < 3; i++) send(int'($urandom_range(2047)), 0, 3, 256, 1'b1);
        bus.phase_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.wave_out !== 10'd512 || bus.wave_vld !== 1'b0 || bus.rom_en !== 1'b0) begin
            nerr++;
            $display("FAIL midreset: out=%0d vld=%0b en=%0b want out=512 vld=0 en=0",
                     bus.wave_out, bus.wave_vld, bus.rom_en);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_held = 512;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            nvec++;
            if (bus.wave_vld !== 1'b0 || bus.wave_out !== 10'd512) begin
                nerr++;
                $display("FAIL post_reset[%0d]: vld=%0b out=%0d want vld=0 out=512",
                         k, bus.wave_vld, bus.wave_out);
            end
        end
        eo = model('h2A0, 0, 0, 256);
        one('h2A0, 0, 0, 256, addr, en, vh, out);
        nvec++;
        if (vh !== 3'b001 || out !== eo) begin
            nerr++;
            $display("FAIL post_reset_sample: out=%0d vh=%03b want out=%0d vh=001", out, vh[2:0], eo);
        end
        exp_held = eo;
    endtask

    initial begin
        test_reset;
        test_sine;
        test_waves;
        test_amp;
        test_stream;
        test_reset_midstream;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dds_wave_shaper.md
Name: dds_wave_shaper

Overview:
- Downstream stage of the DDS phase accumulator: consumes its 11-bit phase code and produces the DAC sample word.
- Adds the phase offset and selects sine, triangle, sawtooth or square.
- Sine comes from an external quarter-wave ROM, with quadrant folding.
- Applies amplitude scaling; output is offset-binary, fully pipelined with a valid strobe.

Parameters:
PW, 11, phase code width (fixed 11 in this design; ROM depth is 2^(PW-2))
DW, 10, output sample width; legal range 4..PW-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
phase_in  input  PW  phase code from the accumulator (accumulator bits [31:21])
phase_vld  input  1  phase_in qualifier; when low, a bubble enters the pipeline
p_off  input  PW  phase offset, added modulo 2^PW
wave_sel  input  2  00 sine, 01 triangle, 10 sawtooth, 11 square
amp  input  9  gain amp/256; values above 256 clamp to 256 (unity)
rom_addr  output  PW-2  quarter-wave ROM address
rom_en  output  1  ROM read enable
rom_data  input  DW-1  ROM magnitude, synchronous, 1-cycle read latency
wave_out  output  DW  offset-binary sample; midscale M = 2^(DW-1)
wave_vld  output  1  wave_out updated this cycle

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous assert, active-low.
- Reset values: all pipeline registers 0, wave_vld=0, rom_en=0, rom_addr=0, wave_out=M.
- Reset mid-stream: all in-flight samples are discarded and no stale wave_vld pulse appears after release.
- There is no backpressure; a sample is accepted on every edge where phase_vld=1.
- S0 (edge N):
  - ph = (phase_in + p_off) mod 2^PW.
  - wave_sel, clamped amp and valid are captured alongside ph.
  - Carry out of the addition is discarded.
- S0 combinational outputs:
  - q = ph[PW-1:PW-2], idx = ph[PW-3:0].
  - rom_addr = q[0] ? ~idx : idx (mirror in quadrants 1 and 3).
  - rom_en = S0 valid.
- S1 (edge N+1): the ROM returns its magnitude. q[1], ph, sel, amp and valid move forward in side registers.
- S2 (edge N+2): raw sample r (DW bits), selected by sel:
  - sine: q[1]=0 gives M+mag; q[1]=1 gives M-1-mag.
  - triangle: t = ph[PW-1] ? ~ph[PW-2:0] : ph[PW-2:0]; r = top DW bits of t.
  - sawtooth: r = top DW bits of ph.
  - square: ph[PW-1]=0 gives 2^DW-1; ph[PW-1]=1 gives 0.
- S3 (edge N+3): scaling and output.
  - s = r-M (signed DW); p = s*amp (signed DW+10).
  - wave_out = (p >>> 8) + M. Arithmetic shift floors toward −inf; no saturation is needed because |result| ≤ |s|.
  - wave_vld=1.
- Latency: a sample accepted at edge N appears on wave_out/wave_vld after edge N+3. Throughput is 1 sample per clock.
- Bubble: wave_vld=0 for that slot and wave_out holds its previous value.
- wave_sel and amp changes take effect per sample, aligned with the phase they were captured with; no glitch or mixing between adjacent samples.
- Wrap-around:
  - ph=2^PW-1 folds to rom_addr=0 in quadrant 3.
  - ph=0 gives rom_addr=0 in quadrant 0, with output M+rom[0].

Test Plan:
All cases use DW=10, PW=11, amp=256 unless stated. The ROM model is a stub with rom_data = rom_addr, registered 1 cycle.

- Sine folding:
  - phase 0x0A0, p_off 0 -> rom_addr 160, wave_out 672.
  - 0x2A0 -> rom_addr 351, out 863.
  - 0x4A0 -> rom_addr 160, out 351.
  - 0x6A0 -> rom_addr 351, out 160.
  - Each output is valid exactly 3 edges after sampling.
- Offset wrap: phase 0x7F0, p_off 0x020 -> ph 0x010, rom_addr 16, out 528.
- Other waveforms:
  - triangle: phase 0x3FF -> 1023; phase 0x400 -> 1023; phase 0x7FF -> 0.
  - sawtooth: phase 0x400 -> 512.
  - square: phase 0x000 -> 1023; phase 0x400 -> 0.
- Amplitude (square, phase 0):
  - amp 255 -> 1021.
  - amp 128 -> 767.
  - amp 0 -> 512.
  - amp 300 -> 1023 (clamped).
- Streaming with per-sample wave_sel/amp changes and phase_vld toggling 1,0,1 -> a 1,0,1 wave_vld pattern delayed by 3 clocks, wave_out held during the bubble, and no cross-sample mixing.
- Reset asserted with 3 samples in flight -> outputs go to wave_out=512, wave_vld=0, rom_en=0 immediately. After release, no wave_vld pulse occurs until new phase_vld input plus 3 clocks.
